// File: rtl/mips_seq_shifter_if.sv
// Request/response bundle between the MIPS core and the sequential shift unit.
// The core drives the request side (master); the shifter answers (slave).
interface mips_seq_shifter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             invalid_op;

    modport master (
        output start, op, data_in, shamt,
        input  busy, done, result, invalid_op
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, done, result, invalid_op
    );
endinterface

// File: rtl/mips_seq_shifter.sv
// Bit-serial SLL/SRL/SRA unit: one bit position per clock, result held until
// the next accepted request completes.
module mips_seq_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input logic              CLK,
    input logic              reset,
    mips_seq_shifter_if.slave bus
);

    localparam logic [1:0] OpSll  = 2'b00;
    localparam logic [1:0] OpSrl  = 2'b01;
    localparam logic [1:0] OpSra  = 2'b10;
    localparam logic [1:0] OpRsvd = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             invalid_q, invalid_d;
    logic [WIDTH-1:0] acc_shift;

    // One-position step of the latched operation.
    always_comb begin
        acc_shift = acc_q;
        case (op_q)
            OpSll:   acc_shift = {acc_q[WIDTH-2:0], 1'b0};
            OpSrl:   acc_shift = {1'b0, acc_q[WIDTH-1:1]};
            OpSra:   acc_shift = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_shift = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        invalid_d = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    acc_d = bus.data_in;
                    cnt_d = bus.shamt;
                    op_d  = bus.op;
                    // Zero shifts and reserved encodings skip straight to DONE.
                    if (bus.shamt == '0 || bus.op == OpRsvd) begin
                        state_d   = StDone;
                        result_d  = bus.data_in;
                        invalid_d = (bus.op == OpRsvd);
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                acc_d = acc_shift;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d  = StDone;
                    result_d = acc_shift;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
        end
    end

    assign bus.busy       = (state_q == StShift);
    assign bus.done       = (state_q == StDone);
    assign bus.result     = result_q;
    assign bus.invalid_op = invalid_q;

endmodule

// File: tb/tb_mips_seq_shifter.sv
// Directed and randomized checks of mips_seq_shifter against an arithmetic
// reference of the shift semantics and request timing.
module tb_mips_seq_shifter;

    logic CLK = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] res_hold;

    mips_seq_shifter_if #(.WIDTH(32), .SHW(5)) bif ();

    mips_seq_shifter #(.WIDTH(32), .SHW(5)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bif)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                          input logic [4:0] n);
        logic signed [31:0] s;
        s = d;
        case (op)
            2'd0:    return d << n;
            2'd1:    return d >> n;
            2'd2:    return s >>> n;
            default: return d;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Issue a request in the current cycle; returns at the negedge of its done cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] n,
                         input bit poke, input string tag);
        int k, busy_n, exp_n;
        bit stable;
        logic [31:0] exp;
        exp_n = (op == 2'b11) ? 0 : int'(n);
        exp   = model(op, d, n);
        bif.start   = 1'b1;
        bif.op      = op;
        bif.data_in = d;
        bif.shamt   = n;
        @(negedge CLK);
        bif.start   = 1'b0;
        bif.op      = 2'($urandom_range(0, 3));
        bif.data_in = $urandom;
        bif.shamt   = 5'($urandom_range(0, 31));
        k = 1;
        busy_n = 0;
        stable = 1'b1;
        while (bif.done !== 1'b1 && k < 80) begin
            if (bif.busy === 1'b1) busy_n++;
            if (bif.result !== res_hold || bif.invalid_op !== 1'b0) stable = 1'b0;
            if (poke && k == 1) begin
                bif.start   = 1'b1;
                bif.op      = 2'b00;
                bif.data_in = ~d;
                bif.shamt   = 5'd1;
            end
            if (poke && k == 2) bif.start = 1'b0;
            @(negedge CLK);
            k++;
        end
        bif.start = 1'b0;
        check({tag, " done"}, {31'd0, bif.done}, 32'd1);
        check({tag, " latency"}, k, exp_n + 1);
        check({tag, " busy_cycles"}, busy_n, exp_n);
        check({tag, " result"}, bif.result, exp);
        check({tag, " invalid_op"}, {31'd0, bif.invalid_op}, {31'd0, op == 2'b11});
        check({tag, " hold"}, {31'd0, stable}, 32'd1);
        res_hold = exp;
    endtask

    initial begin
        bit saw_done;
        logic [1:0] rop;
        logic [4:0] rn;
        logic [31:0] rd;

        reset       = 1'b1;
        bif.start   = 1'b0;
        bif.op      = 2'b00;
        bif.data_in = '0;
        bif.shamt   = '0;
        res_hold    = '0;
        repeat (3) @(negedge CLK);
        check("reset busy", {31'd0, bif.busy}, 32'd0);
        check("reset done", {31'd0, bif.done}, 32'd0);
        check("reset result", bif.result, 32'd0);
        check("reset invalid_op", {31'd0, bif.invalid_op}, 32'd0);
        reset = 1'b0;

        @(negedge CLK);
        issue(2'b00, 32'h0000_0001, 5'd1, 1'b0, "sll1");
        @(negedge CLK);
        check("idle done", {31'd0, bif.done}, 32'd0);
        check("idle result", bif.result, 32'h0000_0002);
        issue(2'b10, 32'hFFFF_FFF8, 5'd2, 1'b0, "sra2");
        @(negedge CLK);
        issue(2'b01, 32'h8000_0000, 5'd31, 1'b0, "srl31");
        @(negedge CLK);
        issue(2'b00, 32'h1234_5678, 5'd0, 1'b0, "sll0");
        @(negedge CLK);
        issue(2'b11, 32'h1234_5678, 5'd5, 1'b0, "rsvd");
        @(negedge CLK);
        issue(2'b10, 32'h1234_5678, 5'd0, 1'b0, "sra0");

        @(negedge CLK);
        issue(2'b00, 32'h0000_0002, 5'd2, 1'b0, "b2b_a");
        issue(2'b01, 32'h0000_0008, 5'd2, 1'b0, "b2b_b");
        @(negedge CLK);
        issue(2'b00, 32'h0000_0003, 5'd6, 1'b1, "poke");

        // Abort SLL(0x1, 10) in its third SHIFT cycle.
        @(negedge CLK);
        bif.start   = 1'b1;
        bif.op      = 2'b00;
        bif.data_in = 32'h0000_0001;
        bif.shamt   = 5'd10;
        @(negedge CLK);
        bif.start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("abort busy", {31'd0, bif.busy}, 32'd0);
        check("abort done", {31'd0, bif.done}, 32'd0);
        check("abort result", bif.result, 32'd0);
        reset    = 1'b0;
        res_hold = '0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (bif.done === 1'b1) saw_done = 1'b1;
        end
        check("abort no_done", {31'd0, saw_done}, 32'd0);
        issue(2'b00, 32'h0000_0001, 5'd3, 1'b0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rn  = 5'($urandom_range(0, 31));
            rd  = $urandom;
            if ($urandom_range(0, 1) == 1) @(negedge CLK);
            issue(rop, rd, rn, (rn >= 5'd2) && ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
        end

        @(negedge CLK);
        check("final idle busy", {31'd0, bif.busy}, 32'd0);
        check("final result hold", bif.result, res_hold);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_seq_shifter.md
Name: mips_seq_shifter

Overview:
Multi-cycle shift responder for the MIPS32 datapath. It executes SLL/SRL/SRA and the variable forms SLLV/SRLV/SRAV; the decode stage supplies the shift amount from either shamt or rs[4:0]. The core issues a request with start and stalls until done. The block then returns the shifted word for write-back to rd. It shifts one bit position per clock, trading area against a full barrel shifter.

Parameters:
WIDTH, 32, data word width in bits.
SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request strobe; sampled only when the block is accepting.
op  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved.
data_in  input  WIDTH  operand (rt value).
shamt  input  SHW  shift amount, 0..WIDTH-1.
busy  output  1  high while in SHIFT state.
done  output  1  one-cycle pulse; result is valid.
result  output  WIDTH  shifted word; held until the next accepted request.
invalid_op  output  1  pulses together with done when op=11.

Behaviour:
- Reset: synchronous, active-high. On reset, state=IDLE, result=0, done=0, busy=0, invalid_op=0, internal counter=0.
- Reset asserted mid-operation aborts the shift on that edge. No done is produced for the aborted request.
- States are IDLE, SHIFT and DONE.
- Accepting condition: state is IDLE or DONE, and start=1.
  - Back-to-back requests are legal. A start in the DONE cycle is accepted.
  - In SHIFT, start is ignored. It is not queued.
- On the accept edge:
  - acc is loaded with data_in, cnt with shamt, and op is latched.
  - Later changes on data_in, shamt and op have no effect on the request in flight.
- If shamt=0 or op=11, the next state is DONE directly. In that case result = data_in, unchanged.
- Otherwise the next state is SHIFT.
- Each SHIFT edge shifts acc by one bit position and decrements cnt:
  - SLL: acc = {acc[WIDTH-2:0], 0}.
  - SRL: acc = {0, acc[WIDTH-1:1]}.
  - SRA: acc = {acc[WIDTH-1], acc[WIDTH-1:1]}; the sign bit is replicated.
- On the SHIFT edge where cnt=1, the next state is DONE and result takes the final acc value.
- Latency: for a request accepted at edge E0 with shamt=n, done is high in exactly the cycle following edge E0+n. That is n+1 cycles from the start cycle, and busy is high for n cycles.
- DONE lasts one cycle:
  - done=1 and busy=0.
  - If a new request is accepted on that edge, the next state is SHIFT or DONE as above. Otherwise the next state is IDLE.
- result updates only when entering DONE. It stays stable through IDLE and SHIFT of the next request until that request's DONE.
- invalid_op=1 only in the DONE cycle of an op=11 request. The datapath error logic uses it to flag a reserved encoding.
- The shift amount is taken modulo WIDTH by construction, since it is SHW bits. No out-of-range case exists.
- There are no combinational paths from inputs to outputs. All outputs are registered or decoded from state.

Test Plan:
- Reset, then SLL with data_in=0x00000001, shamt=1 -> done in the 2nd cycle after start, result=0x00000002, busy high for 1 cycle.
- SRA with data_in=0xFFFFFFF8, shamt=2 -> result=0xFFFFFFFE. Then SRL with 0x80000000, shamt=31 -> busy high for 31 cycles, done in cycle 32, result=0x00000001.
- shamt=0 with data_in=0x12345678 (any op), and op=11 with shamt=5 -> done the cycle after start with result=0x12345678. invalid_op=1 only for the op=11 request.
- Back-to-back: in the DONE cycle of SLL(0x2, 2)=0x8, start SRL(0x8, 2) -> next result=0x2. A start pulsed during busy with a different data_in is ignored, and result is unchanged.
- reset asserted in the 3rd SHIFT cycle of SLL(0x1, 10) -> next cycle state=IDLE, result=0, no done pulse. A following SLL(0x1, 3) completes normally with result=0x00000008.
